// File: rtl/display_pkg.sv
// Shared display types and default 800x600 timing constants.
package display_pkg;

  localparam int unsigned CORDW = 16;

  typedef logic signed [CORDW-1:0] coord_t;

  localparam int DEF_H_RES  = 800;
  localparam int DEF_V_RES  = 600;
  localparam int DEF_H_FP   = 40;
  localparam int DEF_H_SYNC = 128;
  localparam int DEF_H_BP   = 88;
  localparam int DEF_V_FP   = 1;
  localparam int DEF_V_SYNC = 4;
  localparam int DEF_V_BP   = 23;
  localparam int DEF_H_POL  = 1;
  localparam int DEF_V_POL  = 1;

  // Blanking start coordinate: the whole blanking interval sits at negative coordinates.
  function automatic int blank_start(input int fp, input int sync, input int bp);
    return -(fp + sync + bp);
  endfunction

endpackage

// File: rtl/display_axis_counter.sv
// One display axis: counts i_start..i_end by one per enabled clock and wraps.
module display_axis_counter
  import display_pkg::*;
#(
  parameter int unsigned CORDW = display_pkg::CORDW
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic signed [CORDW-1:0] i_start,
  input  logic signed [CORDW-1:0] i_end,
  output logic signed [CORDW-1:0] o_cnt,
  output logic signed [CORDW-1:0] o_cnt_next_c,
  output logic                    o_wrap_c
);

  logic signed [CORDW-1:0] cnt_q;
  logic signed [CORDW-1:0] cnt_d;
  logic                    wrap;

  // Next count: hold, step, or wrap back to the start coordinate.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = i_en && (cnt_q == i_end);
    if (wrap) begin
      cnt_d = i_start;
    end else if (i_en) begin
      cnt_d = cnt_q + $signed(CORDW'(1));
    end
  end

  // Count register, forced to the start coordinate while in reset.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      cnt_q <= i_start;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt        = cnt_q;
  assign o_cnt_next_c = cnt_d;
  assign o_wrap_c     = wrap;

endmodule

// File: rtl/display_timing.sv
// Display timing generator: signed pixel coordinates with blanking at negative
// positions, plus sync, data-enable and line/frame strobes aligned to (o_sx, o_sy).
// Optional frame counter output o_frame_cnt when DISPLAY_TIMING_FCOUNT_EN is defined.
module display_timing
  import display_pkg::*;
#(
  parameter int unsigned CORDW  = display_pkg::CORDW,
  parameter int          H_RES  = DEF_H_RES,
  parameter int          V_RES  = DEF_V_RES,
  parameter int          H_FP   = DEF_H_FP,
  parameter int          H_SYNC = DEF_H_SYNC,
  parameter int          H_BP   = DEF_H_BP,
  parameter int          V_FP   = DEF_V_FP,
  parameter int          V_SYNC = DEF_V_SYNC,
  parameter int          V_BP   = DEF_V_BP,
  parameter int          H_POL  = DEF_H_POL,
  parameter int          V_POL  = DEF_V_POL
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  output logic signed [CORDW-1:0] o_sx,
  output logic signed [CORDW-1:0] o_sy,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic                    o_de,
  output logic                    o_frame,
  output logic                    o_line
`ifdef DISPLAY_TIMING_FCOUNT_EN
  ,
  output logic [15:0]             o_frame_cnt
`endif
);

  localparam int H_STA  = blank_start(H_FP, H_SYNC, H_BP);
  localparam int HS_STA = H_STA + H_FP;
  localparam int HS_END = HS_STA + H_SYNC;
  localparam int V_STA  = blank_start(V_FP, V_SYNC, V_BP);
  localparam int VS_STA = V_STA + V_FP;
  localparam int VS_END = VS_STA + V_SYNC;
  localparam int C_MAX  = (1 << (CORDW - 1)) - 1;
  localparam int C_MIN  = -(1 << (CORDW - 1));

  localparam logic signed [CORDW-1:0] H_STA_C  = CORDW'(H_STA);
  localparam logic signed [CORDW-1:0] H_END_C  = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] HS_STA_C = CORDW'(HS_STA);
  localparam logic signed [CORDW-1:0] HS_END_C = CORDW'(HS_END);
  localparam logic signed [CORDW-1:0] V_STA_C  = CORDW'(V_STA);
  localparam logic signed [CORDW-1:0] V_END_C  = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] VS_STA_C = CORDW'(VS_STA);
  localparam logic signed [CORDW-1:0] VS_END_C = CORDW'(VS_END);
  localparam logic                    H_ACT    = 1'(H_POL);
  localparam logic                    V_ACT    = 1'(V_POL);

  // Elaboration guards: positive active/sync sizes and extents within the signed range.
  if (H_RES <= 0 || V_RES <= 0 || H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_size
    $error("display_timing: H_RES, V_RES, H_SYNC and V_SYNC must be positive");
  end
  if (H_RES - 1 > C_MAX || V_RES - 1 > C_MAX || H_STA < C_MIN || V_STA < C_MIN) begin : g_bad_range
    $error("display_timing: timing extents do not fit in CORDW signed bits");
  end

  logic signed [CORDW-1:0] sx_d;
  logic signed [CORDW-1:0] sy_d;
  logic                    h_wrap_c;
  logic                    v_wrap_c;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    de_q,    de_d;
  logic                    frame_q, frame_d;
  logic                    line_q,  line_d;

  display_axis_counter #(.CORDW(CORDW)) u_h_cnt (
    .i_clk_pix    (i_clk_pix),
    .i_rst_n      (i_rst_n),
    .i_en         (1'b1),
    .i_start      (H_STA_C),
    .i_end        (H_END_C),
    .o_cnt        (o_sx),
    .o_cnt_next_c (sx_d),
    .o_wrap_c     (h_wrap_c)
  );

  display_axis_counter #(.CORDW(CORDW)) u_v_cnt (
    .i_clk_pix    (i_clk_pix),
    .i_rst_n      (i_rst_n),
    .i_en         (h_wrap_c),
    .i_start      (V_STA_C),
    .i_end        (V_END_C),
    .o_cnt        (o_sy),
    .o_cnt_next_c (sy_d),
    .o_wrap_c     (v_wrap_c)
  );

  // Decode flags from the next coordinates so the registered flags line up with o_sx/o_sy.
  always_comb begin
    hsync_d = ~H_ACT;
    vsync_d = ~V_ACT;
    de_d    = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (sx_d >= HS_STA_C && sx_d < HS_END_C) hsync_d = H_ACT;
    if (sy_d >= VS_STA_C && sy_d < VS_END_C) vsync_d = V_ACT;
    de_d    = !sx_d[CORDW-1] && !sy_d[CORDW-1];
    line_d  = (sx_d == H_STA_C);
    frame_d = line_d && (sy_d == V_STA_C);
  end

  // Registered sync, enable and strobe outputs.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      hsync_q <= ~H_ACT;
      vsync_q <= ~V_ACT;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_de    = de_q;
  assign o_frame = frame_q;
  assign o_line  = line_q;

`ifdef DISPLAY_TIMING_FCOUNT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  // Frame count steps in the same edge that raises o_frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_d) frame_cnt_d = frame_cnt_q + 16'(1);
  end

  // Frame counter register.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      frame_cnt_q <= 16'(0);
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

  // Vertical wrap is implied by the horizontal wrap at the last line; not needed here.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap_c;

endmodule
